// File: rtl/vga_timing_gen.sv
// Raster timing generator: hc/vc counters with an IDLE/RUN FSM; every output is registered
// from the current counter position, plus a pixel-fetch request that leads o_de by DE_LAT cycles.
module vga_timing_gen #(
  parameter int   HLOW   = 4,
  parameter int   HBP    = 40,
  parameter int   HACT   = 480,
  parameter int   HFP    = 8,
  parameter int   VLOW   = 4,
  parameter int   VBP    = 12,
  parameter int   VACT   = 272,
  parameter int   VFP    = 8,
  parameter int   CW     = 12,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int   DE_LAT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_req,
  output logic [CW-1:0] o_req_x,
  output logic [CW-1:0] o_req_y,
  output logic          o_sof,
  output logic          o_sol,
  output logic          o_vblank,
  output logic [7:0]    o_frame
);

  localparam int HB = HLOW + HBP;
  localparam int HC = HB + HACT;
  localparam int HD = HC + HFP;
  localparam int VB = VLOW + VBP;
  localparam int VC = VB + VACT;
  localparam int VD = VC + VFP;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;

  logic run, h_last, v_last, v_act, h_act, h_req, hs_act, vs_act, sof;

  always_comb begin
    run    = (state == RUN);
    h_last = (hc == CW'(HD - 1));
    v_last = (vc == CW'(VD - 1));
    v_act  = run && (vc >= CW'(VB)) && (vc < CW'(VC));
    h_act  = (hc >= CW'(HB)) && (hc < CW'(HC));
    // Request window is the active window shifted left by DE_LAT; it stays inside the line.
    h_req  = (hc >= CW'(HB - DE_LAT)) && (hc < CW'(HC - DE_LAT));
    hs_act = run && (hc < CW'(HLOW));
    vs_act = run && (vc < CW'(VLOW));
    sof    = run && (hc == '0) && (vc == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      hc       <= '0;
      vc       <= '0;
      o_hsync  <= ~HS_POL;
      o_vsync  <= ~VS_POL;
      o_de     <= 1'b0;
      o_x      <= '0;
      o_y      <= '0;
      o_req    <= 1'b0;
      o_req_x  <= '0;
      o_req_y  <= '0;
      o_sof    <= 1'b0;
      o_sol    <= 1'b0;
      o_vblank <= 1'b1;
      o_frame  <= '0;
    end else begin
      case (state)
        IDLE: begin
          hc <= '0;
          vc <= '0;
          if (i_en) state <= RUN;
        end
        RUN: begin
          if (h_last) begin
            hc <= '0;
            if (v_last) begin
              vc <= '0;
              // A frame is never cut short by dropping i_en.
              if (!i_en) state <= IDLE;
            end else begin
              vc <= vc + 1'b1;
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      o_hsync  <= hs_act ? HS_POL : ~HS_POL;
      o_vsync  <= vs_act ? VS_POL : ~VS_POL;
      o_de     <= v_act && h_act;
      o_x      <= (v_act && h_act) ? hc - CW'(HB) : '0;
      o_y      <= (v_act && h_act) ? vc - CW'(VB) : '0;
      o_req    <= v_act && h_req;
      o_req_x  <= (v_act && h_req) ? hc + CW'(DE_LAT) - CW'(HB) : '0;
      o_req_y  <= (v_act && h_req) ? vc - CW'(VB) : '0;
      o_sof    <= sof;
      o_sol    <= v_act && (hc == CW'(HB));
      o_vblank <= ~v_act;
      if (sof) o_frame <= o_frame + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster (HD=10, VD=6) against a frame-position model.
module tb_vga_timing_gen;

  localparam int HLOW = 2, HBP = 3, HACT = 4, HFP = 1;
  localparam int VLOW = 1, VBP = 1, VACT = 3, VFP = 1;
  localparam int DL = 2;
  localparam int HB = HLOW + HBP, HC = HB + HACT, HD = HC + HFP;
  localparam int VB = VLOW + VBP, VC = VB + VACT, VD = VC + VFP;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b0;
  localparam logic [62:0] RST_V = {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 12'd0, 12'd0,
                                   1'b0, 1'b0, 1'b1, 8'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        o_hsync, o_vsync, o_de, o_req, o_sof, o_sol, o_vblank;
  logic [11:0] o_x, o_y, o_req_x, o_req_y;
  logic [7:0]  o_frame;
  logic [62:0] obs_v;
  logic [62:0] exp_v;

  int errors = 0;
  int checks = 0;

  vga_timing_gen #(
    .HLOW(HLOW), .HBP(HBP), .HACT(HACT), .HFP(HFP),
    .VLOW(VLOW), .VBP(VBP), .VACT(VACT), .VFP(VFP),
    .CW(12), .HS_POL(HS_POL), .VS_POL(VS_POL), .DE_LAT(DL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_x(o_x), .o_y(o_y),
    .o_req(o_req), .o_req_x(o_req_x), .o_req_y(o_req_y),
    .o_sof(o_sof), .o_sol(o_sol), .o_vblank(o_vblank), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  assign obs_v = {o_hsync, o_vsync, o_de, o_x, o_y, o_req, o_req_x, o_req_y,
                  o_sof, o_sol, o_vblank, o_frame};

  // Reference: a running flag and a linear pixel index within the frame.
  bit running = 1'b0;
  int pos = 0;
  int m_frame = 0;

  function automatic logic [62:0] model_out(input bit r, input int p, input int fr);
    int hc, vc, x, y, rx, ry;
    bit av, de, rq, hs, vs, sof, sol;
    hc  = p % HD;
    vc  = p / HD;
    av  = r && vc >= VB && vc < VC;
    de  = av && hc >= HB && hc < HC;
    rq  = av && hc + DL >= HB && hc + DL < HC;
    hs  = (r && hc < HLOW) ? HS_POL : !HS_POL;
    vs  = (r && vc < VLOW) ? VS_POL : !VS_POL;
    x   = de ? hc - HB : 0;
    y   = de ? vc - VB : 0;
    rx  = rq ? hc + DL - HB : 0;
    ry  = rq ? vc - VB : 0;
    sof = r && p == 0;
    sol = av && hc == HB;
    return {hs, vs, de, 12'(x), 12'(y), rq, 12'(rx), 12'(ry), sof, sol, !av, 8'(fr)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_v   = RST_V;
      running = 1'b0;
      pos     = 0;
      m_frame = 0;
    end else begin
      if (running && pos == 0) m_frame = (m_frame + 1) % 256;
      exp_v = model_out(running, pos, m_frame);
      if (!running) begin
        if (en) begin
          running = 1'b1;
          pos     = 0;
        end
      end else if (pos == HD * VD - 1) begin
        pos     = 0;
        running = en;
      end else begin
        pos++;
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== RST_V) begin
        errors++;
        $display("FAIL reset_state cyc %0d: got %h want %h", i, obs_v, RST_V);
      end
    end
  endtask

  task automatic test_first_frame;
    int first_sof = -1, second_sof = -1, first_req = -1, first_de = -1;
    int de_cnt = 0, vbl_low = 0, max_x = 0, max_y = 0, frame_end = -1;
    logic [11:0] req_x0 = '1, x0 = '1, y0 = '1;
    logic sol0 = 1'b0;
    logic [9:0] hs_bits = '0, vs_bits = '1;
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k <= 130; k++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL first_frame_vec k=%0d: got %h want %h", k, obs_v, exp_v);
      end
      if (o_sof && first_sof >= 0 && second_sof < 0) second_sof = k;
      if (o_sof && first_sof < 0) first_sof = k;
      if (o_req && first_req < 0) begin first_req = k; req_x0 = o_req_x; end
      if (o_de && first_de < 0) begin first_de = k; sol0 = o_sol; x0 = o_x; y0 = o_y; end
      if (k >= 1 && k <= 10) begin
        hs_bits[k-1] = o_hsync;
        vs_bits[k-1] = o_vsync;
      end
      if (k >= 1 && k <= 60) begin
        de_cnt  += int'(o_de);
        vbl_low += int'(!o_vblank);
        if (o_de && int'(o_x) > max_x) max_x = int'(o_x);
        if (o_de && int'(o_y) > max_y) max_y = int'(o_y);
      end
      if (k == 60) frame_end = int'(o_frame);
    end
    checks += 14;
    if (first_sof != 1) begin errors++; $display("FAIL first_sof: got %0d want 1", first_sof); end
    if (hs_bits !== 10'b1111111100) begin errors++; $display("FAIL hsync_line: got %b want 1111111100", hs_bits); end
    if (vs_bits !== 10'b0) begin errors++; $display("FAIL vsync_line: got %b want 0", vs_bits); end
    if (first_req != 24) begin errors++; $display("FAIL first_req: got %0d want 24", first_req); end
    if (req_x0 !== 12'd0) begin errors++; $display("FAIL first_req_x: got %0d want 0", req_x0); end
    if (first_de != 26) begin errors++; $display("FAIL first_de: got %0d want 26", first_de); end
    if (sol0 !== 1'b1) begin errors++; $display("FAIL first_sol: got %b want 1", sol0); end
    if (x0 !== 12'd0 || y0 !== 12'd0) begin errors++; $display("FAIL first_xy: got %0d,%0d want 0,0", x0, y0); end
    if (de_cnt != 12) begin errors++; $display("FAIL de_per_frame: got %0d want 12", de_cnt); end
    if (max_x != 3) begin errors++; $display("FAIL max_x: got %0d want 3", max_x); end
    if (max_y != 2) begin errors++; $display("FAIL max_y: got %0d want 2", max_y); end
    if (vbl_low != 30) begin errors++; $display("FAIL vblank_low: got %0d want 30", vbl_low); end
    if (second_sof - first_sof != 60) begin errors++; $display("FAIL sof_period: got %0d want 60", second_sof - first_sof); end
    if (frame_end != 1) begin errors++; $display("FAIL frame_after_first: got %0d want 1", frame_end); end
  endtask

  task automatic test_stop_restart;
    int pre, fr, got_sof;
    pre = $urandom_range(5, 40);
    for (int i = 0; i < pre; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL pre_stop_vec i=%0d: got %h want %h", i, obs_v, exp_v); end
    end
    en = 1'b0;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL stop_vec i=%0d: got %h want %h", i, obs_v, exp_v); end
    end
    checks++;
    if ({o_hsync, o_vsync, o_de, o_vblank} !== 4'b1101) begin
      errors++;
      $display("FAIL idle_outputs: got %b want 1101", {o_hsync, o_vsync, o_de, o_vblank});
    end
    fr = int'(o_frame);
    en = 1'b1;
    got_sof = 0;
    for (int i = 0; i < 10 && !got_sof; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL restart_vec i=%0d: got %h want %h", i, obs_v, exp_v); end
      if (o_sof) got_sof = 1;
    end
    checks++;
    if (!got_sof) begin
      errors++;
      $display("FAIL restart_sof: got none want pulse within 10 cycles");
    end else if (int'(o_frame) != (fr + 1) % 256) begin
      errors++;
      $display("FAIL restart_frame: got %0d want %0d", o_frame, (fr + 1) % 256);
    end
  endtask

  task automatic test_mid_reset;
    int found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (o_de) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_wait: got no o_de want o_de within 80 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (obs_v !== RST_V) begin errors++; $display("FAIL mid_reset_vals: got %h want %h", obs_v, RST_V); end
    if (obs_v !== exp_v) begin errors++; $display("FAIL mid_reset_model: got %h want %h", obs_v, exp_v); end
    rst = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL random_vec i=%0d: got %h want %h", i, obs_v, exp_v); end
      if ($urandom_range(0, 99) < 3) en = ~en;
      rst = ($urandom_range(0, 999) < 3);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_wrap;
    int sofs = 0;
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256 * HD * VD + 20 && sofs < 256; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL wrap_vec i=%0d: got %h want %h", i, obs_v, exp_v); end
      if (o_sof) begin
        sofs++;
        if (sofs == 255) begin
          checks++;
          if (o_frame !== 8'd255) begin errors++; $display("FAIL frame_255: got %0d want 255", o_frame); end
        end
        if (sofs == 256) begin
          checks++;
          if (o_frame !== 8'd0) begin errors++; $display("FAIL frame_wrap: got %0d want 0", o_frame); end
        end
      end
    end
    checks++;
    if (sofs != 256) begin errors++; $display("FAIL wrap_sof_count: got %0d want 256", sofs); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_stop_restart();
    test_mid_reset();
    test_random();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter HLOW, default 4, hsync pulse width in pixel clocks.
REQ-002 SHALL have parameters HBP / HACT / HFP, defaults 40 / 480 / 8, horizontal back porch / active / front porch.
REQ-003 SHALL have parameters VLOW / VBP / VACT / VFP, defaults 4 / 12 / 272 / 8, vertical sync / back porch / active / front porch in lines.
REQ-004 SHALL have parameter CW, default 12, counter and coordinate width.
REQ-005 SHALL have parameters HS_POL / VS_POL, default 0 / 0, sync active level (0 = active-low).
REQ-006 SHALL have parameter DE_LAT, default 2, lead cycles of the pixel request ahead of o_de; legal range 0..HLOW+HBP.
REQ-007 i_clk  in  1  pixel clock; all logic on rising edge; one clock domain.
REQ-008 i_rst  in  1  synchronous, active-high reset.
REQ-009 i_en  in  1  run request.
REQ-010 o_hsync / o_vsync  out  1 each  sync outputs, polarity per HS_POL / VS_POL.
REQ-011 o_de  out  1  active-video enable.
REQ-012 o_x / o_y  out  CW each  active pixel coordinate.
REQ-013 o_req  out  1  pixel-fetch request, DE_LAT cycles ahead of o_de.
REQ-014 o_req_x / o_req_y  out  CW each  coordinate being requested.
REQ-015 o_sof  out  1  one-cycle start-of-frame pulse.
REQ-016 o_sol  out  1  one-cycle pulse on the first active pixel of each active line.
REQ-017 o_vblank  out  1  high outside active lines.
REQ-018 o_frame  out  8  frame counter.

Function
REQ-019 SHALL define HB=HLOW+HBP, HC=HB+HACT, HD=HC+HFP and VB, VC, VD analogously; internal counters hc (0..HD-1) and vc (0..VD-1) SHALL each be CW bits wide.
REQ-020 SHALL implement FSM IDLE/RUN: IDLE->RUN when i_en=1; the first RUN cycle has hc=vc=0; RUN->IDLE only when hc=HD-1, vc=VD-1 and i_en=0 (the frame always completes).
REQ-021 In RUN, hc SHALL increment each cycle and wrap to 0 after HD-1; vc SHALL increment on each hc wrap and wrap to 0 after VD-1.
REQ-022 In IDLE, hc and vc SHALL hold 0.
REQ-023 All outputs SHALL be registered, reflecting counter position (hc,vc) one cycle later.
REQ-024 o_hsync SHALL be active while hc<HLOW and o_vsync active while vc<VLOW, in RUN only; both SHALL be inactive in IDLE.
REQ-025 o_de SHALL be 1 iff RUN, HB<=hc<HC and VB<=vc<VC; then o_x=hc-HB and o_y=vc-VB, otherwise o_x=o_y=0.
REQ-026 o_req SHALL be 1 iff RUN, HB-DE_LAT<=hc<HC-DE_LAT and VB<=vc<VC; then o_req_x=hc+DE_LAT-HB and o_req_y=vc-VB, else 0. o_req therefore leads o_de by exactly DE_LAT cycles with identical coordinates, and never spans a line wrap.
REQ-027 o_sof SHALL pulse for position (0,0) in RUN; o_sol SHALL pulse at hc=HB within active lines.
REQ-028 o_vblank SHALL be 0 iff RUN and VB<=vc<VC.
REQ-029 o_frame SHALL increment by 1 with each o_sof and wrap 255->0.
REQ-030 With DE_LAT=0, o_req SHALL equal o_de cycle for cycle.

Reset
REQ-031 i_rst=1 SHALL force IDLE, hc=vc=0, and registered outputs: o_hsync=~HS_POL, o_vsync=~VS_POL, o_de=o_req=o_sof=o_sol=0, coordinates 0, o_vblank=1, o_frame=0.
REQ-032 Reset asserted mid-frame SHALL take effect on the next edge without completing the frame; i_rst SHALL dominate i_en.

Verification (HLOW=2, HBP=3, HACT=4, HFP=1, VLOW=1, VBP=1, VACT=3, VFP=1, DE_LAT=2, so HD=10, VD=6)
REQ-033 Release reset with i_en=1 -> o_sof=1 one cycle after the first RUN cycle; o_hsync=0 for 2 cycles, then 1 for 8; o_vsync=0 for 10 cycles.
REQ-034 Same run -> o_req first high 24 cycles after RUN start with o_req_x=0; o_de and o_sol first high at cycle 26 with o_x=0, o_y=0; o_de high 4 cycles per line; o_x runs 0..3.
REQ-035 Full frame -> 3 o_de lines with o_y 0..2; o_vblank low exactly 30 cycles; next o_sof 60 cycles after the first; o_frame=1.
REQ-036 Drop i_en mid-frame -> the frame completes, then IDLE with syncs inactive and o_de=0; reassert i_en -> new o_sof and o_frame increments.
REQ-037 Assert i_rst during an active line -> the next cycle shows all reset values of REQ-031.
REQ-038 Run 256 frames -> o_frame wraps to 0.
